// File: rtl/axis2lbus_seg_pipe.sv
// AXI-Stream to multi-segment LBUS converter: per-segment keep decode, packet framing,
// and a registered 2-entry skid buffer in front of the LBUS output.
module axis2lbus_seg_pipe #(
   parameter int unsigned SEGS      = 4,
   parameter int unsigned SEG_BYTES = 16
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [SEGS*SEG_BYTES*8-1:0]         s_axis_tdata,
   input  logic [SEGS*SEG_BYTES-1:0]           s_axis_tkeep,
   input  logic                                s_axis_tlast,
   input  logic                                s_axis_tvalid,
   output logic                                s_axis_tready,
   output logic [SEGS*SEG_BYTES*8-1:0]         lbus_data,
   output logic [SEGS-1:0]                     lbus_ena,
   output logic [SEGS-1:0]                     lbus_sop,
   output logic [SEGS-1:0]                     lbus_eop,
   output logic [SEGS*$clog2(SEG_BYTES)-1:0]   lbus_mty,
   output logic [SEGS-1:0]                     lbus_err,
   output logic                                lbus_valid,
   input  logic                                lbus_rdy
);

   localparam int unsigned MTY_W  = $clog2(SEG_BYTES);
   localparam int unsigned DATA_W = SEGS*SEG_BYTES*8;

   typedef struct packed {
      logic [DATA_W-1:0]     data;
      logic [SEGS-1:0]       ena;
      logic [SEGS-1:0]       sop;
      logic [SEGS-1:0]       eop;
      logic [SEGS-1:0]       err;
      logic [SEGS*MTY_W-1:0] mty;
   } word_t;

   typedef enum logic {IDLE, IN_PKT} state_t;

   state_t state_q, state_d;
   word_t  head_q, head_d;
   word_t  tail_q, tail_d;
   logic   valid_q, valid_d;
   logic   tail_vld_q, tail_vld_d;
   logic   tready_q, tready_d;
   word_t  beat_w;
   logic   accept, push, pop;

   assign accept = s_axis_tvalid & tready_q;
   // Non-tlast beats with no kept bytes are consumed without producing a word.
   assign push   = accept & (s_axis_tlast | (|s_axis_tkeep));
   assign pop    = valid_q & lbus_rdy;

   // Per-segment keep decode and packet framing of the incoming beat.
   always_comb begin : decode
      logic [SEG_BYTES-1:0] seg_keep;
      logic [SEG_BYTES-1:0] seg_inv;
      logic                 legal;
      int unsigned          zeros;
      int                   hi;
      beat_w   = '0;
      seg_keep = '0;
      seg_inv  = '0;
      legal    = 1'b0;
      zeros    = 0;
      hi       = 0;
      beat_w.data = s_axis_tdata;
      for (int i = 0; i < int'(SEGS); i++) begin
         seg_keep = s_axis_tkeep[i*SEG_BYTES +: SEG_BYTES];
         seg_inv  = ~seg_keep;
         // MSB-contiguous keep means the inverted keep is a run of ones from bit 0.
         legal = (|seg_keep) && ((seg_inv & (seg_inv + SEG_BYTES'(1))) == '0);
         zeros = 0;
         for (int j = 0; j < int'(SEG_BYTES); j++) begin
            if (seg_inv[j]) zeros++;
         end
         beat_w.ena[i] = |seg_keep;
         beat_w.err[i] = (|seg_keep) & ~legal;
         beat_w.mty[i*MTY_W +: MTY_W] = legal ? MTY_W'(zeros) : '0;
         if (!s_axis_tlast && !(&seg_keep)) begin
            beat_w.ena[i] = 1'b1;
            beat_w.err[i] = 1'b1;
            beat_w.mty[i*MTY_W +: MTY_W] = '0;
         end
         if (beat_w.ena[i]) hi = i;
      end
      if (s_axis_tlast) begin
         for (int i = 0; i < int'(SEGS); i++) begin
            beat_w.eop[i] = (i == hi);
         end
         if (s_axis_tkeep == '0) begin
            beat_w.ena[0] = 1'b1;
            beat_w.err[0] = 1'b1;
         end
      end
      beat_w.sop[0] = (state_q == IDLE);
   end

   // Packet framing state, advanced only by emitted beats.
   always_comb begin
      state_d = state_q;
      if (push) begin
         state_d = s_axis_tlast ? IDLE : IN_PKT;
      end
   end

   // Skid buffer: head drives the outputs, tail catches the beat accepted while stalled.
   always_comb begin
      head_d     = head_q;
      tail_d     = tail_q;
      valid_d    = valid_q;
      tail_vld_d = tail_vld_q;
      if (tail_vld_q) begin
         if (pop) begin
            head_d     = tail_q;
            tail_vld_d = 1'b0;
         end
      end else if (valid_q) begin
         if (pop && push) begin
            head_d = beat_w;
         end else if (pop) begin
            valid_d = 1'b0;
         end else if (push) begin
            tail_d     = beat_w;
            tail_vld_d = 1'b1;
         end
      end else if (push) begin
         head_d  = beat_w;
         valid_d = 1'b1;
      end
      tready_d = ~(valid_d & tail_vld_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         head_q     <= '0;
         tail_q     <= '0;
         valid_q    <= 1'b0;
         tail_vld_q <= 1'b0;
         tready_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         valid_q    <= valid_d;
         tail_vld_q <= tail_vld_d;
         tready_q   <= tready_d;
      end
   end

   assign s_axis_tready = tready_q;
   assign lbus_data     = head_q.data;
   assign lbus_ena      = head_q.ena;
   assign lbus_sop      = head_q.sop;
   assign lbus_eop      = head_q.eop;
   assign lbus_mty      = head_q.mty;
   assign lbus_err      = head_q.err;
   assign lbus_valid    = valid_q;

endmodule

// File: tb/tb_axis2lbus_seg_pipe.sv
// Bench for axis2lbus_seg_pipe (SEGS=4, SEG_BYTES=16): directed scenarios plus random
// packets checked against a byte-count based reference model.
module tb_axis2lbus_seg_pipe;

   typedef struct packed {
      logic [511:0] data;
      logic [3:0]   ena;
      logic [3:0]   sop;
      logic [3:0]   eop;
      logic [3:0]   err;
      logic [15:0]  mty;
   } word_t;

   logic         clk = 1'b0;
   logic         rst;
   logic [511:0] s_axis_tdata;
   logic [63:0]  s_axis_tkeep;
   logic         s_axis_tlast;
   logic         s_axis_tvalid;
   logic         s_axis_tready;
   logic [511:0] lbus_data;
   logic [3:0]   lbus_ena, lbus_sop, lbus_eop, lbus_err;
   logic [15:0]  lbus_mty;
   logic         lbus_valid;
   logic         lbus_rdy;

   int    errors = 0;
   int    checks = 0;
   int    cyc    = 0;
   bit    m_in_pkt = 1'b0;
   word_t rx_q[$];
   word_t exp_q[$];

   axis2lbus_seg_pipe #(.SEGS(4), .SEG_BYTES(16)) dut (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
      .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready),
      .lbus_data(lbus_data), .lbus_ena(lbus_ena), .lbus_sop(lbus_sop),
      .lbus_eop(lbus_eop), .lbus_mty(lbus_mty), .lbus_err(lbus_err),
      .lbus_valid(lbus_valid), .lbus_rdy(lbus_rdy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Record every word handed off downstream (handshake completes at the next rising edge).
   always @(negedge clk) begin
      word_t w;
      if (!rst && lbus_valid && lbus_rdy) begin
         w.data = lbus_data; w.ena = lbus_ena; w.sop = lbus_sop;
         w.eop  = lbus_eop;  w.err = lbus_err; w.mty = lbus_mty;
         rx_q.push_back(w);
      end
   end

   // Reference: count kept bytes from each segment's MSB and classify the segment.
   function automatic word_t model(input logic [511:0] d, input logic [63:0] k,
                                   input bit last, input bit in_pkt);
      word_t       w;
      logic [15:0] sk, topmask;
      int          ones, hi;
      w = '0; w.data = d; hi = 0;
      for (int s = 0; s < 4; s++) begin
         sk = k[s*16 +: 16];
         ones = 0;
         while (ones < 16 && sk[15-ones]) ones++;
         topmask = 16'hFFFF << (16 - ones);
         if (!last && sk != 16'hFFFF) begin
            w.ena[s] = 1'b1; w.err[s] = 1'b1;
         end else if (sk == 16'h0) begin
            w.ena[s] = 1'b0;
         end else if (ones > 0 && sk == topmask) begin
            w.ena[s] = 1'b1; w.mty[s*4 +: 4] = 4'(16 - ones);
         end else begin
            w.ena[s] = 1'b1; w.err[s] = 1'b1;
         end
         if (w.ena[s]) hi = s;
      end
      if (last) begin
         if (k == 64'h0) begin
            w.ena[0] = 1'b1; w.err[0] = 1'b1; w.eop[0] = 1'b1;
         end else begin
            w.eop[hi] = 1'b1;
         end
      end
      w.sop[0] = !in_pkt;
      return w;
   endfunction

   function automatic logic [511:0] rnd_data();
      logic [511:0] d;
      for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   // Present one beat until accepted (bounded) and log its expected word.
   task automatic drive(input logic [511:0] d, input logic [63:0] k, input bit last);
      bit ok;
      s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = last; s_axis_tvalid = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 500 && !ok; c++) begin
         @(negedge clk);
         ok = s_axis_tready;
      end
      @(posedge clk); #1;
      s_axis_tvalid = 1'b0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL accept_timeout: tready=%0b, required 1 within 500 cycles", s_axis_tready);
      end
      if (last || k != 64'h0) begin
         exp_q.push_back(model(d, k, last, m_in_pkt));
         m_in_pkt = !last;
      end
   endtask

   task automatic wait_rx(input int n);
      int c;
      c = 0;
      while (rx_q.size() < n && c < 1000) begin
         @(negedge clk); c++;
      end
      checks++;
      if (rx_q.size() < n) begin
         errors++;
         $display("FAIL rx_timeout: got %0d words, required %0d", rx_q.size(), n);
      end
   endtask

   task automatic flush();
      repeat (4) @(posedge clk);
      #1;
      rx_q.delete(); exp_q.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
      s_axis_tkeep = '0; s_axis_tdata = '0; lbus_rdy = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({lbus_data, lbus_ena, lbus_sop, lbus_eop, lbus_err, lbus_mty, lbus_valid,
           s_axis_tready} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: valid=%0b tready=%0b ena=%h, required all 0",
                  lbus_valid, s_axis_tready, lbus_ena);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (s_axis_tready !== 1'b1) begin
         errors++;
         $display("FAIL reset_tready_rise: tready=%0b, required 1", s_axis_tready);
      end
   endtask

   task automatic test_single_beat();
      word_t w;
      drive(rnd_data(), 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      checks++;
      if (lbus_valid !== 1'b1) begin
         errors++;
         $display("FAIL t1_latency: lbus_valid=%0b one cycle after accept, required 1", lbus_valid);
      end
      wait_rx(1);
      w = rx_q.pop_front();
      checks++;
      if ({w.ena, w.sop, w.eop, w.err, w.mty} !== {4'hF, 4'h1, 4'h8, 4'h0, 16'h0} ||
          w.data !== exp_q[0].data) begin
         errors++;
         $display("FAIL t1_fields: ena=%h sop=%h eop=%h err=%h mty=%h, required F 1 8 0 0000",
                  w.ena, w.sop, w.eop, w.err, w.mty);
      end
      flush();
   endtask

   task automatic test_two_beat();
      word_t w;
      drive(rnd_data(), '1, 1'b0);
      drive(rnd_data(), {16'h0, 16'h0, 16'hFFF8, 16'hFFFF}, 1'b1);
      wait_rx(2);
      w = rx_q.pop_front();
      checks++;
      if ({w.ena, w.sop, w.eop, w.err, w.mty} !== {4'hF, 4'h1, 4'h0, 4'h0, 16'h0}) begin
         errors++;
         $display("FAIL t2_beat1: ena=%h sop=%h eop=%h err=%h mty=%h, required F 1 0 0 0000",
                  w.ena, w.sop, w.eop, w.err, w.mty);
      end
      w = rx_q.pop_front();
      checks++;
      if ({w.ena, w.sop, w.eop, w.err, w.mty} !== {4'h3, 4'h0, 4'h2, 4'h0, 16'h0030}) begin
         errors++;
         $display("FAIL t2_beat2: ena=%h sop=%h eop=%h err=%h mty=%h, required 3 0 2 0 0030",
                  w.ena, w.sop, w.eop, w.err, w.mty);
      end
      flush();
   endtask

   task automatic test_illegal_keep();
      word_t w;
      drive(rnd_data(), {48'h0, 16'hF0F0}, 1'b1);
      drive(rnd_data(), '1, 1'b1);
      wait_rx(2);
      w = rx_q.pop_front();
      checks++;
      if ({w.ena, w.sop, w.eop, w.err, w.mty} !== {4'h1, 4'h1, 4'h1, 4'h1, 16'h0}) begin
         errors++;
         $display("FAIL t3_illegal: ena=%h sop=%h eop=%h err=%h mty=%h, required 1 1 1 1 0000",
                  w.ena, w.sop, w.eop, w.err, w.mty);
      end
      w = rx_q.pop_front();
      checks++;
      if (w.sop !== 4'h1) begin
         errors++;
         $display("FAIL t3_back_to_idle: sop=%h, required 1", w.sop);
      end
      flush();
   endtask

   task automatic test_zero_keep();
      word_t w;
      drive(rnd_data(), '1, 1'b0);
      drive(rnd_data(), 64'h0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (rx_q.size() != 1 || lbus_valid !== 1'b0) begin
         errors++;
         $display("FAIL t5_drop: words=%0d valid=%0b, required 1 word and valid 0",
                  rx_q.size(), lbus_valid);
      end
      drive(rnd_data(), 64'h0, 1'b1);
      wait_rx(2);
      w = rx_q[1];
      checks++;
      if ({w.ena, w.sop, w.eop, w.err, w.mty} !== {4'h1, 4'h0, 4'h1, 4'h1, 16'h0}) begin
         errors++;
         $display("FAIL t5_zero_last: ena=%h sop=%h eop=%h err=%h mty=%h, required 1 0 1 1 0000",
                  w.ena, w.sop, w.eop, w.err, w.mty);
      end
      flush();
   endtask

   task automatic test_backpressure();
      logic [511:0] a, b, c;
      bit ok;
      a = rnd_data(); b = rnd_data(); c = rnd_data();
      exp_q.push_back(model(a, '1, 1'b0, m_in_pkt));
      exp_q.push_back(model(b, '1, 1'b0, 1'b1));
      exp_q.push_back(model(c, '1, 1'b1, 1'b1));
      m_in_pkt = 1'b0;
      lbus_rdy = 1'b0;
      s_axis_tdata = a; s_axis_tkeep = '1; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1;
      @(posedge clk); #1;
      s_axis_tdata = b;
      @(posedge clk); #1;
      checks++;
      if (s_axis_tready !== 1'b0) begin
         errors++;
         $display("FAIL t4_tready_full: tready=%0b after 2 accepts, required 0", s_axis_tready);
      end
      s_axis_tdata = c; s_axis_tlast = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++;
         if (lbus_valid !== 1'b1 || lbus_data !== a || lbus_sop !== 4'h1 ||
             lbus_eop !== 4'h0 || s_axis_tready !== 1'b0) begin
            errors++;
            $display("FAIL t4_hold[%0d]: valid=%0b sop=%h eop=%h tready=%0b data_ok=%0b, required 1 1 0 0 1",
                     i, lbus_valid, lbus_sop, lbus_eop, s_axis_tready, lbus_data === a);
         end
      end
      lbus_rdy = 1'b1;
      ok = 1'b0;
      for (int n = 0; n < 50 && !ok; n++) begin
         @(negedge clk);
         ok = s_axis_tready;
      end
      @(posedge clk); #1;
      s_axis_tvalid = 1'b0;
      wait_rx(3);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (rx_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL t4_order[%0d]: sop=%h eop=%h data_ok=%0b, required sop=%h eop=%h",
                     i, rx_q[i].sop, rx_q[i].eop, rx_q[i].data === exp_q[i].data,
                     exp_q[i].sop, exp_q[i].eop);
         end
      end
      flush();
   endtask

   task automatic test_back_to_back();
      int t0;
      t0 = cyc;
      for (int i = 0; i < 8; i++) drive(rnd_data(), '1, i == 7);
      checks++;
      if (cyc - t0 != 8) begin
         errors++;
         $display("FAIL b2b_rate: %0d cycles for 8 beats, required 8", cyc - t0);
      end
      wait_rx(8);
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (rx_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL b2b_word[%0d]: ena=%h sop=%h eop=%h data_ok=%0b, required ena=%h sop=%h eop=%h",
                     i, rx_q[i].ena, rx_q[i].sop, rx_q[i].eop, rx_q[i].data === exp_q[i].data,
                     exp_q[i].ena, exp_q[i].sop, exp_q[i].eop);
         end
      end
      flush();
   endtask

   task automatic test_random();
      bit          done;
      logic [63:0] k;
      bit          last;
      int          f, b;
      done = 1'b0;
      fork
         begin
            for (int n = 0; n < 300; n++) begin
               last = ($urandom % 4) == 0;
               if (!last) begin
                  case ($urandom % 10)
                     0:       k = 64'h0;
                     1:       k = {$urandom, $urandom};
                     default: k = '1;
                  endcase
               end else begin
                  case ($urandom % 5)
                     0: k = '1;
                     1: k = 64'h0;
                     2: k = {$urandom, $urandom};
                     default: begin
                        f = $urandom % 4; b = $urandom_range(1, 16);
                        k = '0;
                        for (int s = 0; s < 4; s++) begin
                           if (s < f)       k[s*16 +: 16] = 16'hFFFF;
                           else if (s == f) k[s*16 +: 16] = 16'hFFFF << (16 - b);
                        end
                     end
                  endcase
               end
               drive(rnd_data(), k, last);
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk); #1;
               lbus_rdy = ($urandom % 4) != 0;
            end
         end
      join
      lbus_rdy = 1'b1;
      wait_rx(exp_q.size());
      checks++;
      if (rx_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL rand_count: got %0d words, required %0d", rx_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         checks++;
         if (rx_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL rand_word[%0d]: ena=%h sop=%h eop=%h err=%h mty=%h data_ok=%0b, required ena=%h sop=%h eop=%h err=%h mty=%h",
                     i, rx_q[i].ena, rx_q[i].sop, rx_q[i].eop, rx_q[i].err, rx_q[i].mty,
                     rx_q[i].data === exp_q[i].data,
                     exp_q[i].ena, exp_q[i].sop, exp_q[i].eop, exp_q[i].err, exp_q[i].mty);
         end
      end
      flush();
   endtask

   task automatic test_reset_mid_pkt();
      word_t w;
      lbus_rdy = 1'b0;
      drive(rnd_data(), '1, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({lbus_data, lbus_ena, lbus_sop, lbus_eop, lbus_err, lbus_mty, lbus_valid,
           s_axis_tready} !== '0) begin
         errors++;
         $display("FAIL t6_reset_clear: valid=%0b tready=%0b ena=%h sop=%h, required all 0",
                  lbus_valid, s_axis_tready, lbus_ena, lbus_sop);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      rx_q.delete(); exp_q.delete();
      m_in_pkt = 1'b0;
      lbus_rdy = 1'b1;
      drive(rnd_data(), '1, 1'b1);
      wait_rx(1);
      w = rx_q.pop_front();
      checks++;
      if (w.sop !== 4'h1 || w.eop !== 4'h8) begin
         errors++;
         $display("FAIL t6_sop_after_reset: sop=%h eop=%h, required 1 8", w.sop, w.eop);
      end
      flush();
   endtask

   initial begin
      test_reset();
      test_single_beat();
      test_two_beat();
      test_illegal_keep();
      test_zero_keep();
      test_backpressure();
      test_back_to_back();
      test_random();
      test_reset_mid_pkt();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
